// File: rtl/insai_wb_arbiter_pkg.sv
// Shared types for the insAI writeback collector.
// xlen_t / exception_t mirror the core's riscv / ariane_pkg definitions so the
// slice stands alone; insai_wb_entry_t is the buffered FU result record.
package insai_wb_arbiter_pkg;

  localparam int unsigned XLEN              = 64;
  localparam int unsigned TRANS_ID_BITS     = 3;
  localparam int unsigned INSAI_NR_WB_PORTS = 2;

  typedef logic [XLEN-1:0] xlen_t;

  typedef struct packed {
    xlen_t cause;
    xlen_t tval;
    logic  valid;
  } exception_t;

  typedef struct packed {
    xlen_t                    result;
    logic [TRANS_ID_BITS-1:0] trans_id;
    exception_t               ex;
  } insai_wb_entry_t;

  // Index width that stays at least one bit for single-element ranges.
  function automatic int unsigned idx_bits(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/insai_wb_arbiter_if.sv
// FU result / scoreboard writeback bundle.
//   slave  : the collector (takes FU results + wb_ready_i, drives stall + wb_*)
//   master : the environment (FUs and scoreboard)
interface insai_wb_arbiter_if
  import insai_wb_arbiter_pkg::*;
#(
  parameter int unsigned NrPorts = INSAI_NR_WB_PORTS
) ();

  logic       [NrPorts-1:0]                    fu_valid_i;
  xlen_t      [NrPorts-1:0]                    fu_result_i;
  logic       [NrPorts-1:0][TRANS_ID_BITS-1:0] fu_trans_id_i;
  exception_t [NrPorts-1:0]                    fu_exception_i;
  logic       [NrPorts-1:0]                    fu_stall_o;

  logic                     wb_valid_o;
  logic                     wb_ready_i;
  xlen_t                    wb_result_o;
  logic [TRANS_ID_BITS-1:0] wb_trans_id_o;
  exception_t               wb_exception_o;

  modport slave (
    input  fu_valid_i, fu_result_i, fu_trans_id_i, fu_exception_i, wb_ready_i,
    output fu_stall_o, wb_valid_o, wb_result_o, wb_trans_id_o, wb_exception_o
  );

  modport master (
    output fu_valid_i, fu_result_i, fu_trans_id_i, fu_exception_i, wb_ready_i,
    input  fu_stall_o, wb_valid_o, wb_result_o, wb_trans_id_o, wb_exception_o
  );

endinterface

// File: rtl/insai_wb_fifo.sv
// Circular FIFO of insai_wb_entry_t for one FU result port.
//   clk_i, rst_ni : clock, async active-low reset
//   flush_i       : empties the FIFO; push/pop in that cycle are ignored
//   push_i/data_i : write request and entry
//   pop_i/data_o  : read request and head entry
//   count_o, full_o, empty_o : occupancy
// A push into a full FIFO is only taken when a pop frees the slot the same cycle.
module insai_wb_fifo
  import insai_wb_arbiter_pkg::*;
#(
  parameter int unsigned Depth = 2
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   flush_i,
  input  logic                   push_i,
  input  insai_wb_entry_t        data_i,
  input  logic                   pop_i,
  output insai_wb_entry_t        data_o,
  output logic [$clog2(Depth):0] count_o,
  output logic                   full_o,
  output logic                   empty_o
);

  localparam int unsigned PtrW = $clog2(Depth);
  localparam int unsigned CntW = PtrW + 1;

  insai_wb_entry_t mem_q [Depth];
  logic [PtrW-1:0] rptr_q, wptr_q;
  logic [CntW-1:0] cnt_q;
  logic            do_push, do_pop;

  assign full_o  = (cnt_q == CntW'(Depth));
  assign empty_o = (cnt_q == '0);
  assign do_pop  = pop_i && !empty_o && !flush_i;
  assign do_push = push_i && !flush_i && (!full_o || do_pop);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rptr_q <= '0;
      wptr_q <= '0;
      cnt_q  <= '0;
      for (int unsigned i = 0; i < Depth; i++) mem_q[i] <= '0;
    end else if (flush_i) begin
      rptr_q <= '0;
      wptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      if (do_push) begin
        mem_q[wptr_q] <= data_i;
        wptr_q        <= wptr_q + 1'b1;
      end
      if (do_pop) rptr_q <= rptr_q + 1'b1;
      if (do_push && !do_pop)      cnt_q <= cnt_q + 1'b1;
      else if (!do_push && do_pop) cnt_q <= cnt_q - 1'b1;
    end
  end

  assign data_o  = mem_q[rptr_q];
  assign count_o = cnt_q;

endmodule

// File: rtl/insai_wb_arbiter.sv
// Writeback collector for the insAI FUs (mac8_FU, mix_unit).
//   clk_i, rst_ni : clock, async active-low reset
//   flush_i       : discards all buffered results (rr_q is kept)
//   bus (slave)   : per-port FU results in, fu_stall_o out,
//                   single scoreboard writeback port (wb_valid_o/wb_ready_i/...)
// Every FU pulse lands in its own FIFO; heads are drained one per cycle
// round-robin. All wb_* outputs depend only on registered state.
module insai_wb_arbiter
  import insai_wb_arbiter_pkg::*;
#(
  parameter int unsigned NrPorts = INSAI_NR_WB_PORTS,
  parameter int unsigned Depth   = 2
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                flush_i,
  insai_wb_arbiter_if.slave   bus
);

  localparam int unsigned RrW  = idx_bits(NrPorts);
  localparam int unsigned CntW = $clog2(Depth) + 1;

  insai_wb_entry_t push_data [NrPorts];
  insai_wb_entry_t head      [NrPorts];
  logic [CntW-1:0] count     [NrPorts];
  logic [NrPorts-1:0] empty, full, pop, stall;

  logic [RrW-1:0]  rr_q, grant, cand;
  logic            any_valid, handshake;
  insai_wb_entry_t sel;

  for (genvar p = 0; p < NrPorts; p++) begin : g_port
    assign push_data[p] = '{result:   bus.fu_result_i[p],
                            trans_id: bus.fu_trans_id_i[p],
                            ex:       bus.fu_exception_i[p]};
    assign pop[p] = handshake && (grant == RrW'(p));

    insai_wb_fifo #(.Depth(Depth)) u_fifo (
      .clk_i   (clk_i),
      .rst_ni  (rst_ni),
      .flush_i (flush_i),
      .push_i  (bus.fu_valid_i[p]),
      .data_i  (push_data[p]),
      .pop_i   (pop[p]),
      .data_o  (head[p]),
      .count_o (count[p]),
      .full_o  (full[p]),
      .empty_o (empty[p])
    );

    // FUs must honour fu_stall_o; a push into a full FIFO without a pop is lost.
    a_no_overflow: assert property (@(posedge clk_i) disable iff (!rst_ni)
      !(bus.fu_valid_i[p] && !flush_i && full[p] && !pop[p]));
  end

  // Stall one entry early: a result from last cycle's issue may still arrive.
  always_comb begin
    stall = '0;
    for (int unsigned i = 0; i < NrPorts; i++) stall[i] = (count[i] >= CntW'(Depth - 1));
  end
  assign bus.fu_stall_o = stall;

  // First non-empty port at or after rr_q, modulo NrPorts.
  always_comb begin
    grant     = '0;
    cand      = '0;
    any_valid = 1'b0;
    for (int unsigned i = 0; i < NrPorts; i++) begin
      cand = RrW'((32'(rr_q) + i) % NrPorts);
      if (!any_valid && !empty[cand]) begin
        any_valid = 1'b1;
        grant     = cand;
      end
    end
  end

  assign handshake = any_valid && bus.wb_ready_i && !flush_i;
  assign sel       = head[grant];

  assign bus.wb_valid_o     = any_valid;
  assign bus.wb_result_o    = any_valid ? sel.result   : '0;
  assign bus.wb_trans_id_o  = any_valid ? sel.trans_id : '0;
  assign bus.wb_exception_o = any_valid ? sel.ex       : '0;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rr_q <= '0;
    end else if (handshake) begin
      rr_q <= (grant == RrW'(NrPorts - 1)) ? '0 : grant + 1'b1;
    end
  end

endmodule
